// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer.
//   - state_e  : sequencer states (FETCH, DECODE, EXEC, MEM, HALT)
//   - opcode_e : instruction opcodes held in IR[15:12]
//   - fs_e     : ALU function-select codes driven on fs
//   - IR field positions and small decode helpers
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_SHR  = 4'b0111,
        OP_MOVB = 4'b1000,
        OP_LD   = 4'b1001,
        OP_ST   = 4'b1010,
        OP_LDI  = 4'b1011,
        OP_BZ   = 4'b1100,
        OP_BNZ  = 4'b1101,
        OP_JMP  = 4'b1110,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        FS_ADD   = 4'b0000,
        FS_SUB   = 4'b0001,
        FS_AND   = 4'b0010,
        FS_OR    = 4'b0011,
        FS_XOR   = 4'b0100,
        FS_NOT   = 4'b0101,
        FS_SHL   = 4'b0110,
        FS_SHR   = 4'b0111,
        FS_MOVB  = 4'b1000,
        FS_PASSA = 4'b1011
    } fs_e;

    // IR field positions (LSB of each field) and widths
    localparam int unsigned IR_W      = 16;
    localparam int unsigned IR_OP_LSB = 12;
    localparam int unsigned IR_DA_LSB = 9;
    localparam int unsigned IR_AA_LSB = 6;
    localparam int unsigned IR_BA_LSB = 3;
    localparam int unsigned REG_W     = 3;
    localparam int unsigned IMM_W     = 9;
    localparam int unsigned OFF_W     = 6;

    function automatic opcode_e ir_op(input logic [IR_W-1:0] ir);
        return opcode_e'(ir[IR_OP_LSB +: 4]);
    endfunction

    // Opcodes 0000..1000 map directly onto an ALU function
    function automatic logic is_alu_op(input opcode_e op);
        return (op <= OP_MOVB);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational strobe decode for the ALU control sequencer.
// Ports:
//   rst       in   synchronous reset; forces all strobes idle while high
//   state     in   current sequencer state
//   op        in   opcode of the instruction held in IR
//   mem_ready in   memory handshake (qualifies the LD writeback in MEM)
//   fs        out  ALU function select (FS_PASSA when no ALU op active)
//   b_sel     out  ALU B source: 0 = register BA, 1 = immediate
//   wb_sel    out  writeback source: 0 = ALU, 1 = memory read data
//   reg_we    out  register-file write enable
//   mem_req   out  memory access request
//   mem_we    out  memory write strobe
//   addr_sel  out  memory address source: 0 = pc, 1 = ALU result
//   halted    out  high in HALT state
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_e     state,
    input  opcode_e    op,
    input  logic       mem_ready,
    output logic [3:0] fs,
    output logic       b_sel,
    output logic       wb_sel,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       halted
);

    always_comb begin
        fs       = FS_PASSA;
        b_sel    = 1'b0;
        wb_sel   = 1'b0;
        reg_we   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        halted   = 1'b0;

        // Reset overrides the registered state so an in-flight access is
        // dropped in the same cycle rst is seen.
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                end
                ST_DECODE: begin
                end
                ST_EXEC: begin
                    if (is_alu_op(op)) begin
                        fs     = op;
                        reg_we = 1'b1;
                    end else if (op == OP_LDI) begin
                        fs     = FS_MOVB;
                        b_sel  = 1'b1;
                        reg_we = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op == OP_ST);
                    // Load data is written back on the completing edge
                    if (op == OP_LD && mem_ready) begin
                        reg_we = 1'b1;
                        wb_sel = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for the 16-bit ALU datapath.
// Fetches instructions, decodes them and drives the register file, ALU
// and memory strobes: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH, HALT absorbing.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mem_rdata         memory read data (instruction or load data)
//   mem_ready         memory handshake; access completes when mem_req & mem_ready
//   z                 ALU zero flag, sampled in EXEC for BZ/BNZ
//   mem_req, mem_we   memory request and write strobe
//   addr_sel          memory address source: 0 = pc, 1 = ALU result
//   pc                program counter
//   da, aa, ba        register addresses from IR
//   fs                ALU function select
//   b_sel, const_out  ALU B source select and zero-extended immediate
//   wb_sel, reg_we    writeback source select and register write enable
//   halted            high in HALT state
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic            z,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      da,
    output logic [2:0]      aa,
    output logic [2:0]      ba,
    output logic [3:0]      fs,
    output logic            b_sel,
    output logic [15:0]     const_out,
    output logic            wb_sel,
    output logic            reg_we,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    opcode_e         op;
    logic [PC_W-1:0] br_off;

    assign op = ir_op(ir_q);

    // Sign-extend the 6-bit branch offset to the pc width
    assign br_off = PC_W'($signed(ir_q[OFF_W-1:0]));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LD, OP_ST: state_d = ST_MEM;
                    OP_BZ:        if (z)  pc_d = pc_q + br_off;
                    OP_BNZ:       if (!z) pc_d = pc_q + br_off;
                    OP_JMP:       pc_d = ir_q[PC_W-1:0];
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    alu_ctrl_decode u_decode (
        .rst       (rst),
        .state     (state_q),
        .op        (op),
        .mem_ready (mem_ready),
        .fs        (fs),
        .b_sel     (b_sel),
        .wb_sel    (wb_sel),
        .reg_we    (reg_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .halted    (halted)
    );

    assign pc        = pc_q;
    assign da        = ir_q[IR_DA_LSB +: REG_W];
    assign aa        = ir_q[IR_AA_LSB +: REG_W];
    assign ba        = ir_q[IR_BA_LSB +: REG_W];
    assign const_out = {{(16 - IMM_W){1'b0}}, ir_q[IMM_W-1:0]};

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: instruction-level reference model
// driven by directed and randomized instruction streams.
module tb_alu_ctrl_seq;

    localparam int unsigned PC_W     = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        z;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic [7:0]  pc;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [3:0]  fs;
    logic        b_sel;
    logic [15:0] const_out;
    logic        wb_sel;
    logic        reg_we;
    logic        halted;

    int unsigned n_checks;
    int unsigned n_errors;
    int          model_pc;

    alu_ctrl_seq #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .z         (z),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .pc        (pc),
        .da        (da),
        .aa        (aa),
        .ba        (ba),
        .fs        (fs),
        .b_sel     (b_sel),
        .const_out (const_out),
        .wb_sel    (wb_sel),
        .reg_we    (reg_we),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset from any state, check idle outputs, release, check resume
    task automatic apply_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        check_eq("rst_mem_req",  32'(mem_req),  0);
        check_eq("rst_mem_we",   32'(mem_we),   0);
        check_eq("rst_reg_we",   32'(reg_we),   0);
        check_eq("rst_b_sel",    32'(b_sel),    0);
        check_eq("rst_wb_sel",   32'(wb_sel),   0);
        check_eq("rst_addr_sel", 32'(addr_sel), 0);
        check_eq("rst_fs",       32'(fs),       32'hB);
        check_eq("rst_halted",   32'(halted),   0);
        next_cycle();
        mem_ready = 1'b1;
        #1;
        check_eq("rst_pc",       32'(pc),       32'(RESET_PC));
        check_eq("rst_req_held", 32'(mem_req),  0);
        rst = 1'b0;
        #1;
        check_eq("rst_resume_req", 32'(mem_req),  1);
        check_eq("rst_resume_sel", 32'(addr_sel), 0);
        model_pc = int'(RESET_PC);
    endtask

    // Runs one instruction, starting in the low phase of a FETCH cycle.
    // wf / wm are the number of mem_ready-low cycles in FETCH / MEM.
    task automatic run_instr(input logic [15:0] ins, input logic zin,
                             input int unsigned wf, input int unsigned wm);
        logic [3:0] op;
        logic       is_ld;
        logic       is_st;
        int         off;
        logic [3:0] exp_fs;
        op    = ins[15:12];
        is_ld = (op == 4'd9);
        is_st = (op == 4'd10);

        // FETCH
        for (int unsigned i = 0; i < wf; i++) begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            #1;
            check_eq("fetch_wait_req", 32'(mem_req), 1);
            check_eq("fetch_wait_pc",  32'(pc),      32'(model_pc));
            next_cycle();
        end
        mem_ready = 1'b1;
        mem_rdata = ins;
        #1;
        check_eq("fetch_req",      32'(mem_req),  1);
        check_eq("fetch_addr_sel", 32'(addr_sel), 0);
        check_eq("fetch_mem_we",   32'(mem_we),   0);
        check_eq("fetch_reg_we",   32'(reg_we),   0);
        check_eq("fetch_pc",       32'(pc),       32'(model_pc));
        next_cycle();
        model_pc = (model_pc + 1) % 256;

        // DECODE
        mem_ready = 1'($urandom);
        z         = 1'($urandom);
        #1;
        check_eq("dec_mem_req", 32'(mem_req), 0);
        check_eq("dec_reg_we",  32'(reg_we),  0);
        check_eq("dec_fs",      32'(fs),      32'hB);
        check_eq("dec_pc",      32'(pc),      32'(model_pc));
        check_eq("dec_da",      32'(da),      32'(ins[11:9]));
        check_eq("dec_aa",      32'(aa),      32'(ins[8:6]));
        check_eq("dec_ba",      32'(ba),      32'(ins[5:3]));
        next_cycle();

        if (op == 4'hF) begin
            for (int unsigned i = 0; i < 20; i++) begin
                mem_ready = 1'($urandom);
                z         = 1'($urandom);
                #1;
                check_eq("halt_halted",  32'(halted),  1);
                check_eq("halt_mem_req", 32'(mem_req), 0);
                check_eq("halt_reg_we",  32'(reg_we),  0);
                check_eq("halt_mem_we",  32'(mem_we),  0);
                check_eq("halt_pc",      32'(pc),      32'(model_pc));
                next_cycle();
            end
            return;
        end

        // EXEC
        if (op <= 4'd8)       exp_fs = op;
        else if (op == 4'd11) exp_fs = 4'd8;
        else                  exp_fs = 4'hB;
        z         = zin;
        mem_ready = 1'($urandom);
        #1;
        check_eq("exec_fs",      32'(fs),      32'(exp_fs));
        check_eq("exec_b_sel",   32'(b_sel),   32'(op == 4'd11));
        check_eq("exec_reg_we",  32'(reg_we),  32'(op <= 4'd8 || op == 4'd11));
        check_eq("exec_mem_req", 32'(mem_req), 0);
        check_eq("exec_wb_sel",  32'(wb_sel),  0);
        if (op == 4'd11) begin
            check_eq("exec_const", 32'(const_out), 32'(ins[8:0]));
            check_eq("exec_da",    32'(da),        32'(ins[11:9]));
        end
        off = int'(ins[5:0]);
        if (ins[5]) off = off - 64;
        if ((op == 4'd12 && zin) || (op == 4'd13 && !zin))
            model_pc = (model_pc + off + 256) % 256;
        if (op == 4'd14)
            model_pc = int'(ins[7:0]);
        next_cycle();

        // MEM
        if (is_ld || is_st) begin
            for (int unsigned i = 0; i < wm; i++) begin
                mem_ready = 1'b0;
                #1;
                check_eq("mem_wait_req",    32'(mem_req),  1);
                check_eq("mem_wait_sel",    32'(addr_sel), 1);
                check_eq("mem_wait_we",     32'(mem_we),   32'(is_st));
                check_eq("mem_wait_reg_we", 32'(reg_we),   0);
                check_eq("mem_wait_fs",     32'(fs),       32'hB);
                next_cycle();
            end
            mem_ready = 1'b1;
            #1;
            check_eq("mem_req",    32'(mem_req),  1);
            check_eq("mem_sel",    32'(addr_sel), 1);
            check_eq("mem_we",     32'(mem_we),   32'(is_st));
            check_eq("mem_reg_we", 32'(reg_we),   32'(is_ld));
            check_eq("mem_wb_sel", 32'(wb_sel),   32'(is_ld));
            next_cycle();
        end
    endtask

    initial begin
        logic [15:0] ins;
        n_checks  = 0;
        n_errors  = 0;
        model_pc  = 0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        z         = 1'b0;
        @(negedge clk);
        apply_reset();

        // Directed cases
        run_instr(16'h0298, 1'b0, 0, 0);   // ADD
        run_instr(16'hB3FF, 1'b0, 0, 0);   // LDI
        run_instr(16'hE005, 1'b0, 0, 0);   // JMP 5
        run_instr(16'hC03E, 1'b1, 0, 0);   // BZ taken -> 4
        run_instr(16'hE005, 1'b0, 0, 0);
        run_instr(16'hC03E, 1'b0, 0, 0);   // BZ not taken -> 6
        run_instr(16'hE005, 1'b0, 0, 0);
        run_instr(16'hD03E, 1'b1, 0, 0);   // BNZ not taken -> 6
        run_instr(16'hE005, 1'b0, 0, 0);
        run_instr(16'hD03E, 1'b0, 0, 0);   // BNZ taken -> 4
        run_instr(16'h9298, 1'b0, 1, 3);   // LD with waits
        run_instr(16'hA298, 1'b0, 0, 2);   // ST with waits
        run_instr(16'hE0FF, 1'b0, 0, 0);   // JMP 0xFF
        run_instr(16'h1298, 1'b0, 0, 0);   // pc wraps to 0
        run_instr(16'hE0A5, 1'b0, 2, 0);   // JMP 0xA5
        #1;
        check_eq("jmp_a5_pc", 32'(pc), 32'hA5);

        // Randomized instruction stream
        for (int unsigned n = 0; n < 300; n++) begin
            ins        = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 14));
            run_instr(ins, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset in the middle of an ST memory access
        mem_ready = 1'b1;
        mem_rdata = 16'hA0C0;
        next_cycle();                       // DECODE
        next_cycle();                       // EXEC
        next_cycle();                       // MEM
        mem_ready = 1'b0;
        #1;
        check_eq("st_abort_we_pre", 32'(mem_we), 1);
        next_cycle();
        apply_reset();
        run_instr(16'h0298, 1'b0, 0, 0);

        // Reset in the middle of a stalled fetch
        mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        apply_reset();
        run_instr(16'hB001, 1'b0, 0, 0);

        // HALT is absorbing until reset
        run_instr(16'hF000, 1'b0, 0, 0);
        apply_reset();
        run_instr(16'h0298, 1'b0, 0, 0);
        #1;
        check_eq("final_pc", 32'(pc), 32'(model_pc));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
